// File: rtl/scroll_pkg.sv
// Shared types and helpers for the scroll window engine: blank character,
// FSM state encoding and the circular window index function.
package scroll_pkg;

    localparam logic [7:0] SCROLL_BLANK_CHAR = 8'h20;
    localparam int         IDX_W             = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } scroll_state_t;

    // Callers only ask for pos < len with ptr < len, so ptr+pos < 2*len and
    // a single conditional subtract replaces a full modulo.
    function automatic logic [IDX_W-1:0] win_index(
        input logic [IDX_W-1:0] ptr,
        input logic [IDX_W-1:0] pos,
        input logic [IDX_W-1:0] len
    );
        logic [IDX_W-1:0] sum;
        sum = ptr + pos;
        return (sum >= len) ? (sum - len) : sum;
    endfunction

endpackage

// File: rtl/step_edge_detect.sv
// Rising-edge detector for a divider output sampled in the same clock domain.
// Reset value is a parameter so a held-high divider output gives no step after reset.
module step_edge_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic rise_o
);

    logic sig_q;
    logic sig_d;

    always_comb begin
        sig_d = sig_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= RST_VAL;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign rise_o = sig_in & ~sig_q;

endmodule

// File: rtl/scroll_window_engine.sv
// Circular message scroller: each Step_Clk rising edge advances a read window
// over a writable buffer. Define SCROLL_REVERSE_EN to add the Dir input (reverse scroll).
module scroll_window_engine
    import scroll_pkg::*;
#(
    parameter int                MSG_DEPTH   = 32,
    parameter int                CHAR_W      = 8,
    parameter int                WIN_CHARS   = 4,
    parameter int                PAUSE_STEPS = 2,
    parameter logic [CHAR_W-1:0] BLANK_CHAR  = CHAR_W'(SCROLL_BLANK_CHAR)
) (
    input  logic                           Clk_In,
    input  logic                           Rst_N,
    input  logic                           Step_Clk,
    input  logic                           Run,
`ifdef SCROLL_REVERSE_EN
    input  logic                           Dir,
`endif
    input  logic                           Wr_En,
    input  logic [$clog2(MSG_DEPTH)-1:0]   Wr_Addr,
    input  logic [CHAR_W-1:0]              Wr_Data,
    input  logic                           Len_We,
    input  logic [$clog2(MSG_DEPTH):0]     Len_In,
    output logic [WIN_CHARS*CHAR_W-1:0]    Win_Data,
    output logic                           Step_Pulse,
    output logic                           Wrap_Pulse,
    output logic                           Busy
);

    localparam int AW   = $clog2(MSG_DEPTH);
    localparam int LW   = AW + 1;
    localparam int HC_W = (PAUSE_STEPS > 0) ? $clog2(PAUSE_STEPS + 1) : 1;

    logic                        step_det;
    scroll_state_t               state_q, state_d;
    logic [AW-1:0]               ptr_q, ptr_d;
    logic [LW-1:0]               len_q, len_d;
    logic [HC_W-1:0]             hold_q, hold_d;
    logic                        step_pulse_q, step_pulse_d;
    logic                        wrap_pulse_q, wrap_pulse_d;
    logic                        busy_q, busy_d;
    logic [WIN_CHARS*CHAR_W-1:0] win_q, win_d;

    logic [LW-1:0]               len_clamped;
    logic                        step_wrap;
    logic [AW-1:0]               step_ptr;
    logic [AW-1:0]               wrap_ptr;

    logic [CHAR_W-1:0]           buf_mem [MSG_DEPTH];
    logic [CHAR_W-1:0]           win_char [WIN_CHARS];

    step_edge_detect #(
        .RST_VAL (1'b1)
    ) u_step_edge (
        .clk    (Clk_In),
        .rst_n  (Rst_N),
        .sig_in (Step_Clk),
        .rise_o (step_det)
    );

    // Buffer contents survive reset; only the pointer/length state is cleared.
    always_ff @(posedge Clk_In) begin
        if (Wr_En) begin
            buf_mem[Wr_Addr] <= Wr_Data;
        end
    end

    always_comb begin
        len_clamped = (Len_In > LW'(MSG_DEPTH)) ? LW'(MSG_DEPTH) : Len_In;
    end

    // Where the pointer goes on an accepted step, and whether that is a wrap.
    always_comb begin
        step_wrap = ((LW'(ptr_q) + LW'(1)) == len_q);
        step_ptr  = ptr_q + AW'(1);
        wrap_ptr  = '0;
`ifdef SCROLL_REVERSE_EN
        if (Dir) begin
            step_wrap = (ptr_q == '0);
            step_ptr  = ptr_q - AW'(1);
            wrap_ptr  = AW'(len_q - LW'(1));
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        len_d        = len_q;
        hold_d       = hold_q;
        step_pulse_d = 1'b0;
        wrap_pulse_d = 1'b0;

        if (Len_We) begin
            // A length load wins over a coincident step, which is dropped.
            len_d   = len_clamped;
            ptr_d   = '0;
            hold_d  = '0;
            state_d = ((len_clamped != '0) && Run) ? RUN : IDLE;
        end else if (!Run) begin
            state_d = IDLE;
            hold_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (len_q != '0) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (step_det) begin
                        step_pulse_d = 1'b1;
                        if (step_wrap) begin
                            ptr_d        = wrap_ptr;
                            wrap_pulse_d = 1'b1;
                            if (PAUSE_STEPS > 0) begin
                                state_d = HOLD;
                                hold_d  = HC_W'(PAUSE_STEPS);
                            end
                        end else begin
                            ptr_d = step_ptr;
                        end
                    end
                end
                HOLD: begin
                    if (step_det) begin
                        step_pulse_d = 1'b1;
                        hold_d       = hold_q - HC_W'(1);
                        if (hold_q == HC_W'(1)) begin
                            state_d = RUN;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    hold_d  = '0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIN_CHARS; gi++) begin : g_win
            logic [AW-1:0] idx;
            assign idx = AW'(win_index(IDX_W'(ptr_q), IDX_W'(gi), IDX_W'(len_q)));
            assign win_char[gi] = (IDX_W'(gi) < IDX_W'(len_q)) ? buf_mem[idx] : BLANK_CHAR;
        end
    endgenerate

    // Leftmost window character lands in the most significant bits.
    always_comb begin
        win_d = '0;
        for (int i = 0; i < WIN_CHARS; i++) begin
            win_d[(WIN_CHARS-1-i)*CHAR_W +: CHAR_W] = win_char[i];
        end
    end

    always_ff @(posedge Clk_In or negedge Rst_N) begin
        if (!Rst_N) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            len_q        <= '0;
            hold_q       <= '0;
            step_pulse_q <= 1'b0;
            wrap_pulse_q <= 1'b0;
            busy_q       <= 1'b0;
            win_q        <= {WIN_CHARS{BLANK_CHAR}};
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            len_q        <= len_d;
            hold_q       <= hold_d;
            step_pulse_q <= step_pulse_d;
            wrap_pulse_q <= wrap_pulse_d;
            busy_q       <= busy_d;
            win_q        <= win_d;
        end
    end

    assign Win_Data   = win_q;
    assign Step_Pulse = step_pulse_q;
    assign Wrap_Pulse = wrap_pulse_q;
    assign Busy       = busy_q;

endmodule

// File: tb/tb_scroll_window_engine.sv
// Bench for scroll_window_engine: two instances (hold of 2 steps and no hold)
// checked every cycle against a behavioural model, plus literal window checks.
module tb_scroll_window_engine;

    logic        clk = 1'b0;
    logic        rst_n, step_clk, run, dir, wr_en, len_we;
    logic [4:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [5:0]  len_in;
    logic [31:0] win_data, win_data0;
    logic        step_pulse, step_pulse0, wrap_pulse, wrap_pulse0, busy, busy0;

    int tests = 0;
    int fails = 0;
    int wrap_cnt = 0;
    int wrap_cnt0 = 0;
    int wc, wc0;
    logic last_sp;

    // behavioural model state, index 0 = hold of 2 steps, index 1 = no hold
    logic [7:0]  m_buf [32];
    bit          m_prev, step_now;
    int          m_len [2], m_ptr [2], m_hold [2];
    bit          m_act [2];
    logic [31:0] e_win [2];
    bit          e_step [2], e_wrap [2], e_busy [2];

    always #5 clk = ~clk;

    scroll_window_engine #(.PAUSE_STEPS(2)) u_dut (
        .Clk_In(clk), .Rst_N(rst_n), .Step_Clk(step_clk), .Run(run),
`ifdef SCROLL_REVERSE_EN
        .Dir(dir),
`endif
        .Wr_En(wr_en), .Wr_Addr(wr_addr), .Wr_Data(wr_data),
        .Len_We(len_we), .Len_In(len_in),
        .Win_Data(win_data), .Step_Pulse(step_pulse), .Wrap_Pulse(wrap_pulse), .Busy(busy)
    );

    scroll_window_engine #(.PAUSE_STEPS(0)) u_dut0 (
        .Clk_In(clk), .Rst_N(rst_n), .Step_Clk(step_clk), .Run(run),
`ifdef SCROLL_REVERSE_EN
        .Dir(dir),
`endif
        .Wr_En(wr_en), .Wr_Addr(wr_addr), .Wr_Data(wr_data),
        .Len_We(len_we), .Len_In(len_in),
        .Win_Data(win_data0), .Step_Pulse(step_pulse0), .Wrap_Pulse(wrap_pulse0), .Busy(busy0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_window(input int k);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            if (i < m_len[k]) w[31-8*i -: 8] = m_buf[(m_ptr[k] + i) % m_len[k]];
            else              w[31-8*i -: 8] = 8'h20;
        end
        return w;
    endfunction

    // One clock of the scroller's rules; outputs seen next cycle.
    task automatic model_cycle(input int k, input bit step);
        int pause;
        pause     = (k == 0) ? 2 : 0;
        e_win[k]  = exp_window(k);
        e_step[k] = 1'b0;
        e_wrap[k] = 1'b0;
        if (len_we) begin
            m_len[k]  = (len_in > 6'd32) ? 32 : int'(len_in);
            m_ptr[k]  = 0;
            m_hold[k] = 0;
            m_act[k]  = (m_len[k] != 0) && run;
        end else if (!run) begin
            m_act[k]  = 1'b0;
            m_hold[k] = 0;
        end else if (!m_act[k]) begin
            if (m_len[k] != 0) m_act[k] = 1'b1;
        end else if (step) begin
            e_step[k] = 1'b1;
            if (m_hold[k] > 0) begin
                m_hold[k]--;
            end else if (dir) begin
                if (m_ptr[k] == 0) begin
                    m_ptr[k] = m_len[k] - 1; e_wrap[k] = 1'b1; m_hold[k] = pause;
                end else begin
                    m_ptr[k]--;
                end
            end else begin
                if (m_ptr[k] + 1 == m_len[k]) begin
                    m_ptr[k] = 0; e_wrap[k] = 1'b1; m_hold[k] = pause;
                end else begin
                    m_ptr[k]++;
                end
            end
        end
        e_busy[k] = m_act[k];
    endtask

    initial begin
        for (int a = 0; a < 32; a++) m_buf[a] = 8'h00;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_prev = 1'b1;
                for (int k = 0; k < 2; k++) begin
                    m_len[k] = 0; m_ptr[k] = 0; m_hold[k] = 0; m_act[k] = 1'b0;
                    e_win[k] = 32'h20202020; e_step[k] = 1'b0; e_wrap[k] = 1'b0; e_busy[k] = 1'b0;
                end
            end else begin
                step_now = step_clk && !m_prev;
                m_prev   = step_clk;
                for (int k = 0; k < 2; k++) model_cycle(k, step_now);
                if (wr_en) m_buf[wr_addr] = wr_data;
            end
        end
    end

    always @(negedge clk) begin
        check("win",   win_data,    e_win[0]);
        check("step",  step_pulse,  e_step[0]);
        check("wrap",  wrap_pulse,  e_wrap[0]);
        check("busy",  busy,        e_busy[0]);
        check("win0",  win_data0,   e_win[1]);
        check("step0", step_pulse0, e_step[1]);
        check("wrap0", wrap_pulse0, e_wrap[1]);
        check("busy0", busy0,       e_busy[1]);
        if (wrap_pulse)  wrap_cnt++;
        if (wrap_pulse0) wrap_cnt0++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Rising edge at entry; returns after Win_Data shows the new pointer.
    task automatic step_once();
        step_clk = 1'b1;
        tick(1);
        last_sp = step_pulse;
        tick(1);
        step_clk = 1'b0;
        tick(1);
    endtask

    task automatic load_len(input logic [5:0] l);
        len_in = l;
        len_we = 1'b1;
        tick(1);
        len_we = 1'b0;
        tick(2);
    endtask

    task automatic write_char(input int a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = 5'(a); wr_data = d;
        tick(1);
        wr_en = 1'b0;
    endtask

    logic [79:0] msg;

    initial begin
        rst_n = 1'b1; step_clk = 1'b0; run = 1'b0; dir = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; len_we = 1'b0; len_in = '0;
        #1 rst_n = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            step_clk = ~step_clk;
        end
        check("rst win",  win_data,   32'h20202020);
        check("rst step", step_pulse, 32'h0);
        check("rst busy", busy,       32'h0);
        step_clk = 1'b1;
        rst_n    = 1'b1;
        tick(3);
        check("post-rst step", step_pulse, 32'h0);

        // basic scroll over "HOLA MUNDO"
        step_clk = 1'b0;
        msg = "HOLA MUNDO";
        for (int i = 0; i < 10; i++) write_char(i, msg[79-8*i -: 8]);
        run = 1'b1;
        load_len(6'd10);
        check("load win", win_data, 32'h484F4C41);
        step_once();
        check("first step pulse", last_sp, 32'h1);
        step_once();
        step_once();
        check("three steps", win_data, 32'h41204D55);

        // wrap at 10 then hold for two steps
        wc = wrap_cnt;
        for (int i = 0; i < 7; i++) step_once();
        check("wrap once", wrap_cnt - wc, 32'd1);
        check("wrapped win", win_data, 32'h484F4C41);
        step_once();
        step_once();
        check("held win", win_data, 32'h484F4C41);
        step_once();
        check("after hold", win_data, 32'h4F4C4120);
        check("no hold win", win_data0, 32'h41204D55);

        // run drop at ptr 5 and resume
        for (int i = 0; i < 4; i++) step_once();
        check("ptr5 win", win_data, 32'h4D554E44);
        run = 1'b0;
        tick(2);
        check("frozen busy", busy, 32'h0);
        step_once();
        step_once();
        check("frozen win", win_data, 32'h4D554E44);
        run = 1'b1;
        tick(2);
        step_once();
        check("resume win", win_data, 32'h554E444F);

        // short message "OK" padded with blanks
        write_char(0, "O");
        write_char(1, "K");
        load_len(6'd2);
        check("ok win", win_data0, 32'h4F4B2020);
        wc0 = wrap_cnt0;
        for (int i = 0; i < 4; i++) begin
            step_once();
            check("ok alt", win_data0, (i % 2 == 0) ? 32'h4B4F2020 : 32'h4F4B2020);
        end
        check("ok wraps", wrap_cnt0 - wc0, 32'd2);
        check("ok held", win_data, 32'h4F4B2020);

        // Len_We in the same cycle as a step edge drops the step
        step_clk = 1'b1; len_in = 6'd10; len_we = 1'b1;
        tick(1);
        len_we = 1'b0;
        check("collide step", step_pulse, 32'h0);
        tick(1);
        step_clk = 1'b0;
        tick(1);
        check("collide win", win_data, 32'h4F4B4C41);

`ifdef SCROLL_REVERSE_EN
        dir = 1'b1;
        wc  = wrap_cnt;
        step_once();
        check("rev win", win_data, 32'h4F4F4B4C);
        check("rev wrap", wrap_cnt - wc, 32'd1);
        dir = 1'b0;
`endif

        // length above depth clamps to 32
        for (int i = 10; i < 32; i++) write_char(i, 8'h61 + 8'(i));
        load_len(6'd40);
        check("clamp win", win_data, 32'h4F4B4C41);
        step_once();
        check("clamp step", win_data, 32'h4B4C4120);
        wc = wrap_cnt;
        for (int i = 0; i < 31; i++) step_once();
        check("clamp wrap", wrap_cnt - wc, 32'd1);
        check("clamp wrapped win", win_data, 32'h4F4B4C41);

        // zero length goes idle and blanks; length one wraps every step
        load_len(6'd0);
        check("len0 busy", busy, 32'h0);
        check("len0 win", win_data, 32'h20202020);
        load_len(6'd1);
        check("len1 win", win_data, 32'h4F202020);
        wc = wrap_cnt; wc0 = wrap_cnt0;
        for (int i = 0; i < 3; i++) step_once();
        check("len1 wraps0", wrap_cnt0 - wc0, 32'd3);
        check("len1 wraps", wrap_cnt - wc, 32'd1);

        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/scroll_window_engine.md
Name: scroll_window_engine

Overview:
- Consumer stage directly downstream of the scroll-rate clock divider.
- Samples the divider's slow square wave (Step_Clk) in the Clk_In domain and turns each rising edge into a one-cycle step.
- Each step advances a circular read window over a writable message buffer.
- Presents a 4-character window to the display driver.

Parameters:
- MSG_DEPTH, 32: message buffer entries; power of 2, max 256.
- CHAR_W, 8: bits per character (ASCII).
- WIN_CHARS, 4: characters in the output window.
- PAUSE_STEPS, 2: extra steps held at wrap before scrolling resumes; 0 means no hold.
- BLANK_CHAR, 8'h20: character output for unused or empty positions.

Ports:
- Clk_In, in, 1: system clock.
- Rst_N, in, 1: asynchronous active-low reset.
- Step_Clk, in, 1: divider slow clock output; generated in the Clk_In domain, so no synchronizer is needed.
- Run, in, 1: 1 = scroll; 0 = freeze window.
- Wr_En, in, 1: write one character into the buffer.
- Wr_Addr, in, $clog2(MSG_DEPTH): write address.
- Wr_Data, in, CHAR_W: write character.
- Len_We, in, 1: load message length.
- Len_In, in, $clog2(MSG_DEPTH)+1: length value, 0..MSG_DEPTH.
- Win_Data, out, WIN_CHARS*CHAR_W: window; leftmost character in the MSBs.
- Step_Pulse, out, 1: registered one-cycle pulse per accepted step.
- Wrap_Pulse, out, 1: one-cycle pulse when the pointer wraps to 0.
- Busy, out, 1: high in RUN or HOLD.

Behaviour:
- Reset (Rst_N=0, async):
  - Ptr=0, Msg_Len=0, state IDLE, Step_Q=1.
  - Win_Data = all BLANK_CHAR.
  - Step_Pulse=0, Wrap_Pulse=0, Busy=0.
  - Buffer contents are not reset.
  - Step_Q resets to 1 because the divider holds its output high when disabled; no spurious step after reset.
- Edge detect:
  - Step_Q <= Step_Clk every cycle.
  - Step_Det = Step_Clk & ~Step_Q.
  - Step_Det in cycle N gives Step_Pulse=1 in cycle N+1.
  - Ptr updates at the same edge.
  - Win_Data reflects the new Ptr one cycle later, at N+2.
  - Falling edges are ignored.
- Window:
  - Position i = buf[(Ptr+i) mod Msg_Len] for i < Msg_Len; otherwise BLANK_CHAR.
  - Msg_Len < WIN_CHARS pads the right side with BLANK_CHAR.
  - Win_Data is re-registered every cycle, so a buffer write appears on Win_Data 2 cycles after Wr_En.
- Length:
  - Len_We loads min(Len_In, MSG_DEPTH) and forces Ptr=0.
  - If new length is 0 → IDLE; else → RUN if Run=1.
  - Len_We has priority over a coincident step; that step is dropped.
- FSM:
  - IDLE: Busy=0, Ptr held. Leaves to RUN when Run=1 and Msg_Len≠0.
  - RUN: on a step, Ptr <= Ptr+1. If Ptr+1 == Msg_Len: Ptr <= 0, Wrap_Pulse=1, and go to HOLD with Hold_Cnt=PAUSE_STEPS (stay in RUN if PAUSE_STEPS=0).
  - HOLD: on a step, Hold_Cnt decrements; Ptr stays 0. When Hold_Cnt reaches 0 → RUN.
  - Run=0 in RUN or HOLD → IDLE. Ptr is frozen (not cleared) and Hold_Cnt cleared; scrolling resumes from Ptr when Run returns to 1.
- Msg_Len=1: every step wraps; Wrap_Pulse fires on each step.
- Simultaneous Wr_En and step: both take effect; there is no write/read conflict (the write lands in the buffer, the read uses the next cycle's contents).
- Wr_Addr ≥ MSG_DEPTH cannot occur because of the address width.

Optional Feature:
- Macro: SCROLL_REVERSE_EN.
- Defined:
  - Adds input port Dir (1 bit); 0 = forward, 1 = reverse.
  - Reverse step: Ptr <= (Ptr==0) ? Msg_Len-1 : Ptr-1.
  - Wrap_Pulse fires on the 0 → Msg_Len-1 transition, followed by HOLD as in forward mode.
  - A Dir change takes effect on the next step.
- Undefined:
  - No Dir port; forward only.

Decomposition:
- Shared package scroll_pkg:
  - BLANK_CHAR default.
  - State encoding: IDLE=2'd0, RUN=2'd1, HOLD=2'd2.
  - Function window index (ptr+i mod len).
- Sub-module step_edge_detect:
  - Step_Q register and rising-edge pulse.
  - Reset value parameterised (default 1).
  - Reusable for other divider consumers.

Test Plan:
- Reset then idle: Rst_N low with Step_Clk toggling → Win_Data=32'h20202020, no Step_Pulse; after release with Step_Clk held 1 → no step.
- Basic scroll: load "HOLA MUNDO", Len=10, Run=1, 3 rising Step_Clk edges → Win_Data "A MU"; Step_Pulse one cycle after each edge; Win_Data changes 2 cycles after each edge.
- Wrap and hold: Len=10, PAUSE_STEPS=2, 10 steps → Wrap_Pulse once, Ptr=0 held for 2 steps, 3rd step → Ptr=1.
- Short message: Len=2, "OK" → Win_Data "OK  " padded with blanks; each step alternates the window "OK  "/"KO  " with a Wrap_Pulse on every return to "OK  " (with PAUSE_STEPS=0).
- Run drop and resume: Run=0 at Ptr=5 → Busy=0, steps ignored; Run=1 → next step gives Ptr=6.
- Len_We collision: Len_We in the same cycle as Step_Det → Ptr=0, no Step_Pulse; with SCROLL_REVERSE_EN and Dir=1 from Ptr=0 → Ptr=Len-1 plus Wrap_Pulse.
